// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings for the iterative shift execution unit.
// Optional feature macro: SHIFT_SRA_EN (enables sra decode with sign fill).
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_SLL  = 2'd1,
    OP_SRL  = 2'd2,
    OP_SRA  = 2'd3
  } op_t;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;
  localparam logic [1:0] SEL_SHIFT = 2'b11;

  // Anything that is not a recognised shift passes rt through unchanged.
  function automatic op_t decode_op(input logic [1:0] sel, input logic [5:0] funct);
    decode_op = OP_PASS;
    if (sel == SEL_SHIFT) begin
      case (funct)
        FUNCT_SLL: decode_op = OP_SLL;
        FUNCT_SRL: decode_op = OP_SRL;
`ifdef SHIFT_SRA_EN
        FUNCT_SRA: decode_op = OP_SRA;
`endif
        default:   decode_op = OP_PASS;
      endcase
    end
  endfunction

endpackage

// File: rtl/shift_exec_unit_step.sv
// shift_step: combinational single-step shifter, moves acc by n (0..STEP) bits.
// Optional feature macro: SHIFT_SRA_EN (sign-filling right shift).
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [4:0]        n,
  output logic [DATA_W-1:0] shifted
);

  // Pick the shift flavour for this step; pass-through for anything else.
  always_comb begin
    shifted = acc;
    case (op_t'(op))
      OP_SLL:  shifted = acc << n;
      OP_SRL:  shifted = acc >> n;
`ifdef SHIFT_SRA_EN
      OP_SRA:  shifted = DATA_W'($signed(acc) >>> n);
`endif
      default: shifted = acc;
    endcase
  end

endmodule

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: multi-cycle sll/srl(/sra) unit for the EX stage, shifting
// STEP bits per clock with a start/busy/done handshake.
// Optional feature macro: SHIFT_SRA_EN (funct 6'h03 decodes to sra).
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        sel_operaB1,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t            state;
  state_t            state_nxt;
  op_t               op_q;
  op_t               op_dec;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_shifted;
  logic [4:0]        rem;
  logic [4:0]        n;
  logic              accept;

  assign op_dec = decode_op(sel_operaB1, funct);
  assign accept = start && (state != ST_SHIFT);

  // Never shift past the remaining amount, so the final step may be short.
  always_comb begin
    n = (rem < STEP_W) ? rem : STEP_W;
  end

  shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .op      (op_q),
    .acc     (acc),
    .n       (n),
    .shifted (acc_shifted)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE can chain straight into SHIFT.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (rem == 5'd0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_SHIFT : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accept, iterative shifting, and result update on finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      rem    <= '0;
      op_q   <= OP_PASS;
      result <= '0;
    end else if (accept) begin
      acc  <= rt_data;
      op_q <= op_dec;
      rem  <= (op_dec == OP_PASS) ? 5'd0 : shamt;
    end else if (state == ST_SHIFT) begin
      if (rem == 5'd0) begin
        result <= acc;
      end else begin
        acc <= acc_shifted;
        rem <= rem - n;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: randomized scoreboard bench for shift_exec_unit.
// Follows SHIFT_SRA_EN the same way the design does.
module tb_shift_exec_unit;

  localparam int DATA_W = 32;
  localparam int STEP   = 4;

  typedef struct {
    logic [31:0] result;
    int          cycle;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        sel = 2'b00;
  logic [5:0]        funct = 6'h00;
  logic [4:0]        shamt = 5'd0;
  logic [DATA_W-1:0] rtData = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t scoreQ[$];
  logic [31:0] expResult = '0;
  int   lastDoneEdge = 0;
  int   busyFrom = 1;
  int   busyTo = 0;
  bit   monitorOn = 1'b0;

  shift_exec_unit #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sel_operaB1 (sel),
    .funct       (funct),
    .shamt       (shamt),
    .rt_data     (rtData),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Architectural meaning of each instruction, independent of step count.
  function automatic logic [31:0] refResult(input logic [1:0] s, input logic [5:0] f,
                                            input logic [4:0] sa, input logic [31:0] rt);
    if (s == 2'b11 && f == 6'h00) return rt << sa;
    if (s == 2'b11 && f == 6'h02) return rt >> sa;
`ifdef SHIFT_SRA_EN
    if (s == 2'b11 && f == 6'h03) return $signed(rt) >>> sa;
`endif
    return rt;
  endfunction

  function automatic int refSteps(input logic [1:0] s, input logic [5:0] f, input logic [4:0] sa);
    bit isShift;
    isShift = (s == 2'b11) && (f == 6'h00 || f == 6'h02);
`ifdef SHIFT_SRA_EN
    isShift = isShift || (s == 2'b11 && f == 6'h03);
`endif
    return isShift ? (int'(sa) + STEP - 1) / STEP : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Holds start for 'hold' edges; the model decides which edge is accepted.
  task automatic applyStimulus(input logic [1:0] s, input logic [5:0] f, input logic [4:0] sa,
                               input logic [31:0] rt, input int hold);
    int edgeNo;
    int k;
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sel = s; funct = f; shamt = sa; rtData = rt; start = 1'b1;
      edgeNo = cyc + 1;
      if (edgeNo > lastDoneEdge) begin
        k = refSteps(s, f, sa);
        e.result = refResult(s, f, sa, rt);
        e.cycle  = edgeNo + k + 1;
        scoreQ.push_back(e);
        busyFrom     = edgeNo;
        busyTo       = edgeNo + k;
        lastDoneEdge = edgeNo + k + 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    sel = 2'($urandom); funct = 6'($urandom); shamt = 5'($urandom); rtData = $urandom;
  endtask

  task automatic waitUntil(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("wait_timeout", 32'(cyc), 32'(target));
  endtask

  // Monitor: pops the scoreboard whenever the DUT is due to complete.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && monitorOn) begin
      if (scoreQ.size() > 0 && scoreQ[0].cycle == cyc) begin
        e = scoreQ.pop_front();
        expResult = e.result;
        checkOutput("done_pulse", 32'(done), 32'd1);
      end else begin
        checkOutput("done_quiet", 32'(done), 32'd0);
      end
      checkOutput("busy", 32'(busy), 32'((cyc >= busyFrom) && (cyc <= busyTo)));
      checkOutput("result", result, expResult);
    end
  end

  initial begin
    logic [5:0] fTab [4];
    logic [1:0] s;
    logic [5:0] f;
    logic [4:0] sa;
    fTab[0] = 6'h00; fTab[1] = 6'h02; fTab[2] = 6'h03; fTab[3] = 6'h01;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);

    // Directed cases from the intended usage.
    applyStimulus(2'b11, 6'h00, 5'd4, 32'h0000_00F1, 1);
    waitUntil(lastDoneEdge + 2);
    applyStimulus(2'b11, 6'h03, 5'd31, 32'h8000_0000, 1);
    waitUntil(lastDoneEdge + 2);
    applyStimulus(2'b11, 6'h02, 5'd31, 32'h8000_0000, 1);
    waitUntil(lastDoneEdge + 2);
    applyStimulus(2'b00, 6'h00, 5'd9, 32'hDEAD_BEEF, 1);
    waitUntil(lastDoneEdge + 2);
    applyStimulus(2'b11, 6'h00, 5'd0, 32'hDEAD_BEEF, 1);
    waitUntil(lastDoneEdge + 2);
    applyStimulus(2'b11, 6'h03, 5'd5, 32'hF000_0000, 1);
    waitUntil(lastDoneEdge + 2);

    // Back-to-back: start held across the finishing edge and the DONE cycle.
    applyStimulus(2'b11, 6'h00, 5'd8, 32'h1234_5678, 1);
    waitUntil(lastDoneEdge - 2);
    applyStimulus(2'b11, 6'h02, 5'd13, 32'hCAFE_F00D, 2);
    waitUntil(lastDoneEdge + 2);

    // Start pulsed mid-shift must be ignored.
    applyStimulus(2'b11, 6'h00, 5'd20, 32'h0000_0003, 1);
    applyStimulus(2'b00, 6'h02, 5'd1, 32'hFFFF_FFFF, 1);
    waitUntil(lastDoneEdge + 2);

    // Reset during the second shift cycle of an sll by 8.
    applyStimulus(2'b11, 6'h00, 5'd8, 32'h0000_00FF, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    scoreQ.delete();
    expResult = '0;
    busyFrom = 1; busyTo = 0; lastDoneEdge = 0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(2'b11, 6'h02, 5'd7, 32'h8765_4321, 1);
    waitUntil(lastDoneEdge + 2);

    // Randomized traffic, including pulses that land while busy.
    for (int i = 0; i < 60; i++) begin
      s  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      f  = fTab[$urandom_range(0, 3)];
      sa = 5'($urandom);
      applyStimulus(s, f, sa, $urandom, $urandom_range(1, 2));
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    waitUntil(lastDoneEdge + 3);
    checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Multi-cycle shift execution unit for the EX stage of the MIPS datapath. It sits directly downstream of the shift-operand select decoder and consumes its 2-bit `sel_operaB1` together with `funct`, `shamt` and the `rt` register value. It performs `sll`, `srl` and, optionally, `sra` iteratively, shifting `STEP` bits per clock. It reports completion with a start/busy/done handshake to the EX-stage controller.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `STEP`, 1: bits shifted per cycle. Must be a power of two, 1..16.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse; sampled on the rising edge.
- `sel_operaB1`, input, 2: from the decoder; `2'b11` means shift operation.
- `funct`, input, 6: R-type function field.
- `shamt`, input, 5: shift amount.
- `rt_data`, input, `DATA_W`: operand to shift.
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: one-cycle completion pulse.
- `result`, output, `DATA_W`: shifted value; held until the next completion.

## Operation
- States:
  - IDLE (reset state)
  - SHIFT
  - DONE
- Accepting a request:
  - `start` is accepted only in IDLE or DONE. In SHIFT it is ignored.
  - On accept:
    - `acc <= rt_data`
    - `rem <= shamt`
    - latch `op`
    - go to SHIFT
- Op decode at accept:
  - `sel_operaB1==2'b11` and `funct==6'h00`: SLL.
  - `sel_operaB1==2'b11` and `funct==6'h02`: SRL.
  - `sel_operaB1==2'b11` and `funct==6'h03`: SRA (only if the macro is enabled).
  - Any other combination: PASS. PASS forces `rem <= 0`.
- Each SHIFT cycle:
  - If `rem==0`: `result <= acc`, go to DONE.
  - Otherwise: shift `acc` by `n = min(STEP, rem)` and set `rem <= rem - n`.
  - SLL and SRL fill with zeros. SRA fills with `acc[DATA_W-1]`.
- DONE:
  - `done=1` for exactly one cycle.
  - Next state is SHIFT if `start` is asserted, otherwise IDLE.
- Width rules:
  - `rem` is 5 bits.
  - `shamt` up to 31 is legal with `DATA_W=32`. No wrap or modulo is applied.
  - The shift never exceeds `rem`.
- Reset (any time, including mid-SHIFT):
  - state = IDLE; `busy=0`, `done=0`, `result=0`, `acc=0`, `rem=0`.
  - An in-flight operation is discarded and produces no `done`.

## Timing
- Let `k = ceil(shamt/STEP)`; `k=0` for PASS or `shamt=0`.
- Start sampled at edge E0:
  - `busy` is high from E0 to E(k+1).
  - `done` is high for the cycle following E(k+1).
  - `result` is valid from E(k+1) onward.
- Latency from the start edge to `done`: k+1 cycles. Worst case with STEP=1 and shamt=31: 32 cycles.
- Back-to-back requests:
  - `start` during DONE is accepted. The next `done` arrives k'+2 cycles after the previous `done`.
  - `result` changes only at a transition into DONE.
- Inputs need to be stable only on the accepting edge. Changes during SHIFT have no effect.

## Configuration
- `SHIFT_SRA_EN`:
  - Defined: `funct==6'h03` decodes to SRA with sign fill.
  - Undefined: `funct==6'h03` decodes to PASS, the SRA fill logic is not synthesised, and `result = rt_data` after 1 cycle.

## Structure
- Shared package `shift_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the op encoding (PASS, SLL, SRL, SRA);
  - the funct constants `FUNCT_SLL=6'h00`, `FUNCT_SRL=6'h02`, `FUNCT_SRA=6'h03`;
  - the constant `SEL_SHIFT=2'b11`.
- One sub-module, `shift_step`: combinational, shifts `acc` by `n` (0..STEP) according to `op`. It is instantiated once in the datapath.
- The FSM and the `rem`/`acc` registers live in the top module.

## Test plan
- **SLL by 4, STEP=1:** sel=2'b11, funct=6'h00, shamt=4, rt=32'h0000_00F1 → result=32'h0000_0F10; `done` 5 cycles after the start edge; `busy` high for 5 cycles.
- **SRA vs. SRL, STEP=4:** `SHIFT_SRA_EN` defined; rt=32'h8000_0000, shamt=31.
  - funct=6'h03 → result=32'hFFFF_FFFF; `done` after 9 cycles.
  - Same with funct=6'h02 → result=32'h0000_0001.
- **PASS and shamt=0:**
  - sel=2'b00, rt=32'hDEAD_BEEF → result=32'hDEAD_BEEF; `done` 1 cycle after start.
  - sel=2'b11, funct=6'h00, shamt=0 → identical result and timing.
- **Back-to-back and ignored start:**
  - `start` held high through DONE → a second operation completes with no IDLE gap.
  - `start` pulsed mid-SHIFT → ignored; `result` and timing are unchanged.
- **Reset mid-operation:** assert `rst_n=0` on SHIFT cycle 2 of an SLL by 8.
  - `busy`, `done` and `result` go to 0 immediately.
  - No `done` pulse follows the release of reset.
  - The next request completes normally.
- **SRA disabled:** with `SHIFT_SRA_EN` undefined, funct=6'h03, shamt=5, rt=32'hF000_0000 → result=32'hF000_0000 after 1 cycle.
